// File: rtl/uart_fifo_pkg.sv
// Shared constants for the buffered UART: register map, status/control bit positions,
// TX sequencer state encoding and a 4-bit count saturation helper.
// No logic, no latency, no backpressure.
package uart_fifo_pkg;

  // Register map (2-bit PIA-style window)
  localparam logic [1:0] REG_RX   = 2'd0;
  localparam logic [1:0] REG_RXCR = 2'd1;
  localparam logic [1:0] REG_TX   = 2'd2;
  localparam logic [1:0] REG_TXCR = 2'd3;

  // addr 1 status bits ([3:0] = saturated rx count)
  localparam int ST_RX_AVAIL    = 7;
  localparam int ST_RX_OVERRUN  = 6;
  localparam int ST_TX_OVERFLOW = 5;
  localparam int ST_TX_FULL     = 4;
  // addr 2 status bits
  localparam int ST2_TX_FULL    = 7;
  localparam int ST2_TX_ACTIVE  = 6;
  // addr 3 status bits ([3:0] = saturated tx count)
  localparam int ST3_LOOPBACK   = 7;

  // addr 3 control write bits
  localparam int CTL_FLUSH_RX   = 0;
  localparam int CTL_FLUSH_TX   = 1;
  localparam int CTL_CLR_FLAGS  = 2;
  localparam int CTL_LOOPBACK   = 3;

  // TX sequencer states
  typedef logic [1:0] tx_state_t;
  localparam tx_state_t TX_IDLE  = 2'd0;
  localparam tx_state_t TX_START = 2'd1;
  localparam tx_state_t TX_WAIT  = 2'd2;

  function automatic logic [3:0] sat4(input logic [8:0] c);
    return (c > 9'd15) ? 4'hF : c[3:0];
  endfunction

endpackage

// File: rtl/async_receiver.sv
// 8N1 serial receiver, oversampled at Baud*Oversampling, samples mid-bit.
// Latency: RxD_data_ready pulses one cycle at the middle of the stop bit.
// Backpressure: none; each byte is presented once and must be taken on the pulse.
// Ports: clk, rst (async high), RxD, RxD_data_ready, RxD_data, RxD_idle (no frame in progress).
module async_receiver #(
  parameter int ClkFrequency = 25000000,
  parameter int Baud         = 115200,
  parameter int Oversampling = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RxD,
  output logic       RxD_data_ready,
  output logic [7:0] RxD_data,
  output logic       RxD_idle
);
  localparam int OS_RAW = ClkFrequency / (Baud * Oversampling);
  localparam int OS_DIV = (OS_RAW < 1) ? 1 : OS_RAW;
  localparam int ODW    = $clog2(OS_DIV + 1);
  localparam int PW     = $clog2(Oversampling + 1);
  localparam int HUNT   = 10 * Oversampling;
  localparam int HW     = $clog2(HUNT + 1);

  logic            rx_s1, rx_s2, tick, busy, armed;
  logic [ODW-1:0]  os_cnt;
  logic [PW-1:0]   phase;
  logic [3:0]      bit_idx;
  logic [HW-1:0]   hunt_cnt;
  logic [7:0]      shift;

  assign tick     = (os_cnt == ODW'(OS_DIV - 1));
  assign RxD_idle = !busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1          <= 1'b1;
      rx_s2          <= 1'b1;
      os_cnt         <= '0;
      phase          <= '0;
      bit_idx        <= 4'd0;
      hunt_cnt       <= '0;
      shift          <= 8'h00;
      busy           <= 1'b0;
      armed          <= 1'b0;
      RxD_data       <= 8'h00;
      RxD_data_ready <= 1'b0;
    end else begin
      rx_s1          <= RxD;
      rx_s2          <= rx_s1;
      os_cnt         <= tick ? '0 : os_cnt + 1'b1;
      RxD_data_ready <= 1'b0;
      if (tick) begin
        if (!armed) begin
          // After reset the line may be mid-frame: wait for a full frame time of
          // continuous idle before trusting a falling edge as a start bit.
          if (!rx_s2)                         hunt_cnt <= '0;
          else if (hunt_cnt == HW'(HUNT - 1)) armed    <= 1'b1;
          else                                hunt_cnt <= hunt_cnt + 1'b1;
        end else if (!busy) begin
          if (!rx_s2) begin
            busy    <= 1'b1;
            phase   <= '0;
            bit_idx <= 4'd0;
          end
        end else begin
          phase <= (phase == PW'(Oversampling - 1)) ? '0 : phase + 1'b1;
          if (phase == PW'(Oversampling / 2 - 1)) begin
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 4'd0) begin
              if (rx_s2) busy <= 1'b0;          // glitch, not a real start bit
            end else if (bit_idx == 4'd9) begin
              busy <= 1'b0;
              if (rx_s2) begin                  // framing error drops the byte
                RxD_data       <= shift;
                RxD_data_ready <= 1'b1;
              end
            end else begin
              shift <= {rx_s2, shift[7:1]};
            end
          end
        end
      end
    end
  end

endmodule

// File: rtl/async_transmitter.sv
// 8N1 serial transmitter, LSB first, one bit every ClkFrequency/Baud cycles.
// Latency: start bit appears on TxD the cycle after TxD_start.
// Backpressure: TxD_start is ignored while TxD_busy is high.
// Ports: clk, rst (async high), TxD_start, TxD_data, TxD (idles high), TxD_busy.
module async_transmitter #(
  parameter int ClkFrequency = 25000000,
  parameter int Baud         = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       TxD_start,
  input  logic [7:0] TxD_data,
  output logic       TxD,
  output logic       TxD_busy
);
  localparam int BIT_DIV = ClkFrequency / Baud;
  localparam int DW      = $clog2(BIT_DIV + 1);

  logic [DW-1:0] div_cnt;
  logic [9:0]    shift;
  logic [3:0]    bits_left;

  assign TxD_busy = (bits_left != 4'd0);
  // Shifting in ones leaves the line high once the stop bit has gone out.
  assign TxD      = shift[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt   <= '0;
      shift     <= '1;
      bits_left <= 4'd0;
    end else if (TxD_start && !TxD_busy) begin
      shift     <= {1'b1, TxD_data, 1'b0};
      bits_left <= 4'd10;
      div_cnt   <= '0;
    end else if (TxD_busy) begin
      if (div_cnt == DW'(BIT_DIV - 1)) begin
        div_cnt   <= '0;
        shift     <= {1'b1, shift[9:1]};
        bits_left <= bits_left - 1'b1;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with combinational head output and occupancy count.
// Latency: a pushed word is visible at dout the cycle after the push.
// Backpressure: push while full is ignored unless a pop happens in the same cycle;
// pop while empty is ignored. flush empties the FIFO and wins over push/pop.
// Ports: clk, rst (async high), push, pop, flush, din, dout (head), full, empty, count.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_fifo.sv
// Buffered Apple-1 style UART: RX/TX FIFOs behind a 2-bit PIA register window.
// Latency: dout is registered (1 cycle); TX bytes start within 2 cycles of transmitter idle.
// Backpressure: RX full drops bytes (sticky overrun) and raises uart_cts early;
// TX full drops writes (sticky overflow).
// Ports: clk, rst (async high), enable/address/w_en/din/dout CPU bus, uart_rx, uart_tx, uart_cts.
// Optional: define UART_FIFO_LOOPBACK_EN for the control bit3 internal loopback.
module uart_fifo
  import uart_fifo_pkg::*;
#(
  parameter int ClkFrequency  = 25000000,
  parameter int Baud          = 115200,
  parameter int Oversampling  = 16,
  parameter int RX_DEPTH      = 16,
  parameter int TX_DEPTH      = 16,
  parameter int CTS_MARGIN    = 4,
  parameter int SKIP_FIRST_TX = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [1:0] address,
  input  logic       w_en,
  input  logic [7:0] din,
  output logic [7:0] dout,
  input  logic       uart_rx,
  output logic       uart_tx,
  output logic       uart_cts
);
  localparam int RX_CW = $clog2(RX_DEPTH) + 1;
  localparam int TX_CW = $clog2(TX_DEPTH) + 1;

  logic             rx_line_in, tx_line_out;
  logic             rx_data_ready, rx_idle, tx_busy, tx_start;
  logic [7:0]       rx_data, rx_head, tx_head, tx_byte, rd_mux;
  logic             rx_full, rx_empty, tx_full, tx_empty;
  logic [RX_CW-1:0] rx_count;
  logic [TX_CW-1:0] tx_count;
  logic             rx_overrun, tx_overflow, skip_armed, loopback, seen_busy;
  tx_state_t        tx_state;

  logic ctl_wr, tx_wr, rx_pop, tx_push, tx_pop;
  logic flush_rx, flush_tx, clr_flags, overrun_evt, overflow_evt;

  assign ctl_wr       = enable && w_en && (address == REG_TXCR);
  assign tx_wr        = enable && w_en && (address == REG_TX);
  assign rx_pop       = enable && !w_en && (address == REG_RX) && !rx_empty;
  assign flush_rx     = ctl_wr && din[CTL_FLUSH_RX];
  assign flush_tx     = ctl_wr && din[CTL_FLUSH_TX];
  assign clr_flags    = ctl_wr && din[CTL_CLR_FLAGS];
  assign overrun_evt  = rx_data_ready && rx_full && !rx_pop;
  assign tx_push      = tx_wr && !skip_armed && !tx_full;
  assign overflow_evt = tx_wr && !skip_armed && tx_full;
  assign tx_pop       = (tx_state == TX_IDLE) && !tx_empty && !tx_busy;
  assign tx_start     = (tx_state == TX_START);

  assign uart_cts = rst || !rx_idle || ((RX_DEPTH - int'(rx_count)) <= CTS_MARGIN);

  uart_sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst), .push(rx_data_ready), .pop(rx_pop), .flush(flush_rx),
    .din(rx_data), .dout(rx_head), .full(rx_full), .empty(rx_empty), .count(rx_count)
  );

  uart_sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst), .push(tx_push), .pop(tx_pop), .flush(flush_tx),
    .din(din), .dout(tx_head), .full(tx_full), .empty(tx_empty), .count(tx_count)
  );

  async_receiver #(.ClkFrequency(ClkFrequency), .Baud(Baud), .Oversampling(Oversampling)) u_rx (
    .clk(clk), .rst(rst), .RxD(rx_line_in), .RxD_data_ready(rx_data_ready),
    .RxD_data(rx_data), .RxD_idle(rx_idle)
  );

  async_transmitter #(.ClkFrequency(ClkFrequency), .Baud(Baud)) u_tx (
    .clk(clk), .rst(rst), .TxD_start(tx_start), .TxD_data(tx_byte),
    .TxD(tx_line_out), .TxD_busy(tx_busy)
  );

`ifdef UART_FIFO_LOOPBACK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         loopback <= 1'b0;
    else if (ctl_wr) loopback <= din[CTL_LOOPBACK];
  end
  assign rx_line_in = loopback ? tx_line_out : uart_rx;
  assign uart_tx    = loopback ? 1'b1 : tx_line_out;
  logic unused_din;
  assign unused_din = ^din[7:4];
`else
  assign loopback   = 1'b0;
  assign rx_line_in = uart_rx;
  assign uart_tx    = tx_line_out;
  logic unused_din;
  assign unused_din = ^{din[7:4], din[CTL_LOOPBACK]};
`endif

  // TX sequencer: WAIT needs busy to rise then fall so the start pulse is never
  // mistaken for completion before the transmitter has registered it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state  <= TX_IDLE;
      tx_byte   <= 8'h00;
      seen_busy <= 1'b0;
    end else begin
      case (tx_state)
        TX_IDLE: if (tx_pop) begin
          tx_byte  <= tx_head;
          tx_state <= TX_START;
        end
        TX_START: begin
          seen_busy <= 1'b0;
          tx_state  <= TX_WAIT;
        end
        TX_WAIT: begin
          if (tx_busy)        seen_busy <= 1'b1;
          else if (seen_busy) tx_state  <= TX_IDLE;
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  // Sticky flags: a same-cycle error event beats the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_overrun  <= 1'b0;
      tx_overflow <= 1'b0;
      skip_armed  <= (SKIP_FIRST_TX != 0);
    end else begin
      if (overrun_evt)     rx_overrun  <= 1'b1;
      else if (clr_flags)  rx_overrun  <= 1'b0;
      if (overflow_evt)    tx_overflow <= 1'b1;
      else if (clr_flags)  tx_overflow <= 1'b0;
      if (tx_wr && skip_armed) skip_armed <= 1'b0;
    end
  end

  always_comb begin
    rd_mux = 8'h00;
    case (address)
      REG_RX:   rd_mux = rx_empty ? 8'h00 : rx_head;
      REG_RXCR: begin
        rd_mux[ST_RX_AVAIL]    = !rx_empty;
        rd_mux[ST_RX_OVERRUN]  = rx_overrun;
        rd_mux[ST_TX_OVERFLOW] = tx_overflow;
        rd_mux[ST_TX_FULL]     = tx_full;
        rd_mux[3:0]            = sat4(9'(rx_count));
      end
      REG_TX: begin
        rd_mux[ST2_TX_FULL]    = tx_full;
        rd_mux[ST2_TX_ACTIVE]  = !tx_empty || (tx_state != TX_IDLE);
      end
      REG_TXCR: begin
        rd_mux[ST3_LOOPBACK]   = loopback;
        rd_mux[3:0]            = sat4(9'(tx_count));
      end
      default: rd_mux = 8'h00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) dout <= 8'h00;
    else     dout <= rd_mux;
  end

endmodule

// File: tb/tb_uart_fifo.sv
// Self-checking bench for uart_fifo: directed phases with random payloads,
// checked against queue-based models of the RX/TX buffers and sticky flags.
module tb_uart_fifo;
  localparam int CLK_HZ = 2_000_000;
  localparam int BAUD   = 62_500;
  localparam int BIT    = CLK_HZ / BAUD;
  localparam int DEPTH  = 16;
  localparam int MARGIN = 4;

  logic       clk = 1'b0, rst = 1'b1, enable = 1'b0, w_en = 1'b0, uart_rx = 1'b1;
  logic [1:0] address = 2'd0;
  logic [7:0] din = 8'h00;
  logic [7:0] dout;
  logic       uart_tx, uart_cts;

  int vectors = 0, miscompares = 0;
  logic [7:0] tx_seen[$], rx_model[$], tx_model[$];
  bit model_overrun = 1'b0, model_overflow = 1'b0;

  always #5 clk = ~clk;

  uart_fifo #(.ClkFrequency(CLK_HZ), .Baud(BAUD), .Oversampling(16), .RX_DEPTH(DEPTH),
              .TX_DEPTH(DEPTH), .CTS_MARGIN(MARGIN), .SKIP_FIRST_TX(1)) dut (
    .clk(clk), .rst(rst), .enable(enable), .address(address), .w_en(w_en), .din(din),
    .dout(dout), .uart_rx(uart_rx), .uart_tx(uart_tx), .uart_cts(uart_cts)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  // Status register 1 as the map defines it, from the model state.
  function automatic logic [7:0] exp_rxcr(input bit txfull);
    int n = rx_model.size();
    return {n != 0, model_overrun, model_overflow, txfull, 4'(n > 15 ? 15 : n)};
  endfunction

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk); address = a; din = d; w_en = 1'b1; enable = 1'b1;
    @(negedge clk); enable = 1'b0; w_en = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
    @(negedge clk); address = a; w_en = 1'b0; enable = 1'b1;
    @(negedge clk); enable = 1'b0; d = dout;
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic [9:0] fr;
    fr = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rx = fr[i];
      repeat (BIT) @(negedge clk);
    end
  endtask

  task automatic wait_tx(input int n, input int budget);
    int c = 0;
    while (tx_seen.size() < n && c < budget) begin @(negedge clk); c++; end
    vectors++;
    assert (tx_seen.size() >= n) else begin
      miscompares++;
      $error("FAIL tx_timeout: observed %0d bytes expected %0d", tx_seen.size(), n);
    end
  endtask

  // Serial line decoder for uart_tx.
  initial begin : tx_mon
    logic [7:0] mb;
    forever begin
      @(negedge clk);
      if (uart_tx === 1'b0 && !rst) begin
        repeat (BIT / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (BIT) @(negedge clk);
          mb[i] = uart_tx;
        end
        repeat (BIT) @(negedge clk);
        tx_seen.push_back(mb);
      end
    end
  end

  initial begin : main
    logic [7:0] r, x, a, b, c;

    // ---- reset ----
    repeat (4) @(negedge clk);
    check("rst_dout", dout, 8'h00);
    check("rst_cts", 8'(uart_cts), 8'h01);
    check("rst_tx", 8'(uart_tx), 8'h01);
    rst = 1'b0;
    @(negedge clk);
    check("cts_after_rst", 8'(uart_cts), 8'h00);
    bus_read(2'd1, r); check("rxcr_rst", r, 8'h00);
    bus_read(2'd2, r); check("tx_stat_rst", r, 8'h00);
    bus_read(2'd3, r); check("txcr_rst", r, 8'h00);
    bus_read(2'd0, r); check("rx_empty_rst", r, 8'h00);

    // ---- first TX write is swallowed ----
    bus_write(2'd2, 8'h7F);
    bus_write(2'd2, 8'h41);
    bus_write(2'd2, 8'h42);
    wait_tx(2, 30 * BIT);
    repeat (12 * BIT) @(negedge clk);
    check("skip_count", 8'(tx_seen.size()), 8'd2);
    check("skip_b0", tx_seen[0], 8'h41);
    check("skip_b1", tx_seen[1], 8'h42);
    bus_read(2'd2, r); check("tx_idle", r, 8'h00);
    tx_seen.delete();

    // ---- RX overrun with 17 bytes, CTS threshold ----
    for (int i = 0; i < 17; i++) begin
      send_byte(8'(i));
      if (rx_model.size() < DEPTH) rx_model.push_back(8'(i));
      else model_overrun = 1'b1;
      check($sformatf("cts_%0d", i + 1), 8'(uart_cts),
            8'((DEPTH - rx_model.size()) <= MARGIN));
    end
    bus_read(2'd1, r); check("rxcr_overrun", r, exp_rxcr(1'b0));
    check("rxcr_overrun_lit", r, 8'hCF);
    while (rx_model.size() > 0) begin
      bus_read(2'd0, r); x = rx_model.pop_front();
      check("rx_pop_order", r, x);
    end
    bus_read(2'd1, r); check("rxcr_drained", r, exp_rxcr(1'b0));
    bus_read(2'd0, r); check("rx_pop_empty", r, 8'h00);
    bus_write(2'd3, 8'h04); model_overrun = 1'b0;
    bus_read(2'd1, r); check("rxcr_clr", r, exp_rxcr(1'b0));

    // ---- simultaneous pop and push while full ----
    for (int i = 0; i < DEPTH; i++) begin
      x = 8'($urandom);
      send_byte(x);
      rx_model.push_back(x);
    end
    x = 8'($urandom);
    fork
      send_byte(x);
      begin : popper
        int cc = 0;
        while (dut.rx_data_ready !== 1'b1 && cc < 20 * BIT) begin @(negedge clk); cc++; end
        address = 2'd0; w_en = 1'b0; enable = 1'b1;
        @(negedge clk); enable = 1'b0; r = dout;
      end
    join
    check("pop_push_full_head", r, rx_model.pop_front());
    rx_model.push_back(x);
    bus_read(2'd1, r); check("rxcr_pop_push", r, exp_rxcr(1'b0));
    while (rx_model.size() > 0) begin
      bus_read(2'd0, r); x = rx_model.pop_front();
      check("rx_order_after", r, x);
    end

    // ---- TX overflow: one byte in flight plus a full FIFO ----
    tx_seen.delete();
    for (int i = 0; i < 20; i++) begin
      x = 8'($urandom);
      bus_write(2'd2, x);
      if (tx_model.size() < DEPTH + 1) tx_model.push_back(x);
      else model_overflow = 1'b1;
    end
    bus_read(2'd2, r); check("tx_stat_full", r, 8'hC0);
    bus_read(2'd1, r); check("rxcr_overflow", r, exp_rxcr(1'b1));
    bus_read(2'd3, r); check("txcr_count", r, 8'h0F);
    wait_tx(tx_model.size(), 17 * 12 * BIT);
    repeat (20 * BIT) @(negedge clk);
    check("tx_emit_count", 8'(tx_seen.size()), 8'(tx_model.size()));
    for (int i = 0; i < 17; i++) check("tx_emit_byte", tx_seen[i], tx_model[i]);
    bus_read(2'd2, r); check("tx_stat_done", r, 8'h00);
    bus_read(2'd1, r); check("rxcr_ovf_sticky", r, exp_rxcr(1'b0));
    bus_write(2'd3, 8'h04); model_overflow = 1'b0;
    bus_read(2'd1, r); check("rxcr_ovf_clr", r, exp_rxcr(1'b0));

    // ---- flush both FIFOs mid-transmission ----
    tx_seen.delete();
    send_byte(8'($urandom)); send_byte(8'($urandom));
    a = 8'($urandom); b = 8'($urandom); c = 8'($urandom);
    bus_write(2'd2, a); bus_write(2'd2, b); bus_write(2'd2, c);
    repeat (4 * BIT) @(negedge clk);
    bus_write(2'd3, 8'h03);
    bus_read(2'd3, r); check("txcr_flushed", r, 8'h00);
    bus_read(2'd2, r); check("tx_active_flushed", r, 8'h40);
    wait_tx(1, 12 * BIT);
    repeat (25 * BIT) @(negedge clk);
    check("flush_emit_count", 8'(tx_seen.size()), 8'd1);
    check("flush_emit_byte", tx_seen[0], a);
    bus_read(2'd1, r); check("rxcr_flushed", r, 8'h00);
    bus_read(2'd2, r); check("tx_stat_flushed", r, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_fifo.md
Name: uart_fifo

Overview:
Buffered successor to the single-byte Apple-1 UART wrapper. It keeps the 2-bit PIA-style register map used by Wozmon at 0xD014-0xD017, and places parametrised RX and TX FIFOs between the CPU bus and the existing async_receiver and async_transmitter. It adds sticky overrun and overflow flags, flush and clear controls, and a FIFO-level-based CTS.

Parameters:
ClkFrequency, 25000000, system clock in Hz, passed to the TX and RX cores
Baud, 115200, serial bit rate
Oversampling, 16, RX oversampling factor
RX_DEPTH, 16, RX FIFO entries; power of two, 2..256
TX_DEPTH, 16, TX FIFO entries; power of two, 2..256
CTS_MARGIN, 4, free RX slots at or below which CTS asserts; must be less than RX_DEPTH
SKIP_FIRST_TX, 1, 1 = drop the first TX-data write after reset (Wozmon DDR setup)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
enable  in  1  one-cycle CPU access strobe
address  in  2  register select
w_en  in  1  write enable
din  in  8  write data
dout  out  8  registered read data
uart_rx  in  1  serial input from host
uart_tx  out  1  serial output to host
uart_cts  out  1  high = host must hold off

Behaviour:
- Reset:
  - dout = 0, uart_cts = 1 while rst is asserted.
  - Both FIFOs empty; all sticky flags = 0; skip flag armed; TX FSM in IDLE.
  - uart_tx idles high (transmitter reset).
- Reads:
  - dout is registered from address every cycle; 1-cycle latency.
  - addr 0: dout = RX head byte, or 0 if empty.
  - addr 1: dout = {rx_avail, rx_overrun, tx_overflow, tx_full, rx_count saturated to 4 bits}.
  - addr 2: dout = {tx_full, tx_active, 6'b0}. tx_active = FIFO non-empty or FSM not IDLE.
  - addr 3: dout = {loopback, 3'b0, tx_count saturated to 4 bits}.
- RX pop:
  - Occurs on address==0 && enable && !w_en && !empty.
  - Exactly one pop per enable strobe. dout captures the head at the same edge as the pop.
- RX push:
  - Occurs on RxD_data_ready. If the FIFO is full, the byte is dropped and rx_overrun is set.
  - Push and pop in the same cycle while full: both occur; no overrun.
  - Pop while empty is ignored, even with a simultaneous push.
- TX push:
  - Occurs on address==2 && enable && w_en.
  - If the skip flag is armed, the write is discarded and the flag clears.
  - Otherwise, if full, the write is dropped and tx_overflow is set; else push din.
- Control write: address==3 && enable && w_en.
  - bit0: flush RX.
  - bit1: flush TX. A byte already handed to the transmitter completes normally.
  - bit2: clear rx_overrun and tx_overflow. A same-cycle overrun event wins over the clear.
  - bit3: loopback, only when the macro is defined.
- TX FSM:
  - IDLE: if the FIFO is non-empty and TxD_busy==0, pop the head into the TX byte register and go to START.
  - START: TxD_start=1 for exactly 1 cycle; go to WAIT.
  - WAIT: hold until TxD_busy has been seen 1 and then 0; go to IDLE.
  - Back-to-back bytes have a gap of at most 2 clk cycles beyond transmitter idle.
- CTS: uart_cts = !RxD_idle || (RX_DEPTH - rx_count) <= CTS_MARGIN.
- Counts are clog2(DEPTH)+1 bits wide. Pointers wrap modulo DEPTH; full is defined as count==DEPTH.
- Reset mid-frame: the frame is aborted; no partial byte is pushed after reset releases.

Optional Feature:
Macro UART_FIFO_LOOPBACK_EN.
- Defined: control bit3 is a loopback register (reset 0). When set:
  - the receiver input is driven from the transmitter output;
  - uart_tx is held high;
  - uart_rx is ignored.
  - addr 3 bit7 reads back the loopback setting.
- Undefined: bit3 writes are ignored, addr 3 bit7 reads 0, and no loopback mux is present.

Decomposition:
- Package uart_fifo_pkg:
  - register address localparams (REG_RX=0, REG_RXCR=1, REG_TX=2, REG_TXCR=3);
  - status bit index constants and control bit index constants;
  - TX FSM state enum (IDLE, START, WAIT).
- Sub-module uart_sync_fifo:
  - parameters WIDTH and DEPTH;
  - ports push, pop, flush, din, dout (head, combinational), full, empty, count;
  - instantiated twice, once for RX and once for TX.

Test Plan:
- Reset, write 0x7F to addr 2, then write 0x41, 0x42 -> first write discarded; serial line carries 0x41 then 0x42 at 115200 baud.
- Inject 17 RX bytes 0x00..0x10 with RX_DEPTH=16, no reads:
  - addr 1 reads 0xCF (avail, overrun, count saturated 15);
  - popping returns 0x00..0x0F;
  - uart_cts is high once 12 bytes are queued.
- Write 20 bytes to TX while the line is busy with TX_DEPTH=16 -> tx_overflow set; addr 2 bit7=1 when full; exactly 17 bytes emitted (1 in flight + 16 queued).
- Read pop and RX push in the same cycle with the FIFO full -> no overrun; count stays 16; order preserved.
- Write 0x04 to addr 3 -> both sticky flags clear. Write 0x03 mid-transmission -> current byte finishes, nothing further is sent, and addr 1 reads 0x00.
- With UART_FIFO_LOOPBACK_EN defined: write 0x08 to addr 3, then send 0x55 -> addr 0 returns 0x55 and uart_tx stays high throughout.
